// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: takes one arbiter winner at a time, holds a one-hot grant until done,
// the requester drops its line, or the hold timer expires; one idle bubble between grants.
module rr_grant_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Next_priority,
  input  logic       Data_Valid,
  input  logic [3:0] Req_bus,
  input  logic       Done,
  output logic       Arb_ack,
  output logic [3:0] Grant,
  output logic [1:0] Grant_idx,
  output logic       Grant_valid,
  output logic       Timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t     r_state;
  logic [7:0] r_cnt;
  logic       w_drop, w_to, w_exit;
  always_comb begin
    w_drop = !Req_bus[Grant_idx];
    w_to   = r_cnt == 8'(TIMEOUT_CYC - 1);
    w_exit = Done || w_drop || w_to;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      Grant       <= 4'b0000;
      Grant_idx   <= 2'b00;
      Grant_valid <= 1'b0;
      Arb_ack     <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      Arb_ack <= 1'b0;
      Timeout <= 1'b0;
      case (r_state)
        IDLE: if (Data_Valid) begin
          r_state     <= GRANT;
          Grant_idx   <= Next_priority;
          Grant       <= 4'b0001 << Next_priority;
          Grant_valid <= 1'b1;
          Arb_ack     <= 1'b1;
          r_cnt       <= 8'd0;
        end
        GRANT: if (w_exit) begin
          r_state     <= RELEASE;
          Grant       <= 4'b0000;
          Grant_valid <= 1'b0;
          r_cnt       <= 8'd0;
          // done and drop outrank the timer, so only a pure expiry pulses Timeout
          Timeout     <= !Done && !w_drop;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rr_grant_ctrl.md
RR_GRANT_CTRL -- requirements
Module: rr_grant_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, legal range 2..255; maximum number of cycles a grant is held without Done.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-low (rst==0 sampled at a rising edge resets the block).
REQ-004 Port: Next_priority  input  2  winner index from the upstream round-robin arbiter.
REQ-005 Port: Data_Valid  input  1  Next_priority is valid this cycle.
REQ-006 Port: Req_bus  input  4  live request lines, same bus the arbiter sees; bit i = requester i.
REQ-007 Port: Done  input  1  granted requester finished its transfer.
REQ-008 Port: Arb_ack  output  1  one-cycle pulse telling the arbiter the winner was taken; arbiter advances only on this pulse.
REQ-009 Port: Grant  output  4  one-hot grant to requesters; all-zero when no grant.
REQ-010 Port: Grant_idx  output  2  binary index of the current grant.
REQ-011 Port: Grant_valid  output  1  a grant is active.
REQ-012 Port: Timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 FSM states SHALL be IDLE, GRANT and RELEASE; all outputs registered.
REQ-014 IDLE: Data_Valid==1 at an edge -> latch Next_priority into Grant_idx, go to GRANT; Data_Valid==0 -> stay IDLE.
REQ-015 Latency: Data_Valid sampled at edge N -> Grant, Grant_valid and Arb_ack high in the cycle after edge N.
REQ-016 Arb_ack SHALL be high for exactly one cycle per accepted winner (first GRANT cycle), never otherwise.
REQ-017 In GRANT, Grant SHALL equal 1<<Grant_idx, Grant_valid=1, and Grant/Grant_idx SHALL be held stable until GRANT is left.
REQ-018 Data_Valid and Next_priority SHALL be ignored in GRANT and RELEASE.
REQ-019 Hold counter: 8 bits, cleared to 0 on GRANT entry, increments each GRANT cycle, cleared on exit; no wrap possible given REQ-001.
REQ-020 GRANT exit conditions, sampled each GRANT cycle including the first, priority order: Done==1; then Req_bus[Grant_idx]==0 (requester dropped); then counter==TIMEOUT_CYC-1 (timeout).
REQ-021 Any GRANT exit -> RELEASE; Timeout pulses one cycle (the RELEASE cycle) only when exit was by timeout.
REQ-022 Done and drop in same cycle as timeout -> no Timeout pulse.
REQ-023 RELEASE lasts exactly one cycle with Grant=0, Grant_valid=0, then IDLE unconditionally; guarantees one idle bubble between consecutive grants, never two grant bits high.
REQ-024 Done asserted outside GRANT SHALL be ignored.
REQ-025 Grant_idx SHALL retain the last granted value in RELEASE and IDLE; only Grant_valid qualifies it.

Reset
REQ-026 rst==0 at an edge SHALL force IDLE, counter=0, Grant=4'b0000, Grant_idx=2'b00, Grant_valid=0, Arb_ack=0, Timeout=0, from any state including mid-grant.
REQ-027 While rst==0 all inputs SHALL be ignored; first possible Arb_ack is the cycle after the first edge with rst==1 and Data_Valid==1.

Verification
REQ-028 Reset then Data_Valid=1, Next_priority=2, Req_bus=4'b0100, Done at 3rd GRANT cycle -> Grant=4'b0100 for 3 cycles, Arb_ack one cycle, then 1 RELEASE cycle with Grant=0, no Timeout.
REQ-029 TIMEOUT_CYC=4, Next_priority=1, Req_bus=4'b0010 held, Done=0 -> Grant=4'b0010 for exactly 4 cycles, then Timeout=1 for one cycle with Grant=0.
REQ-030 Grant on idx 3, Req_bus[3] deasserted in 2nd GRANT cycle -> RELEASE next cycle, no Timeout; Data_Valid held high -> next Arb_ack exactly 2 cycles after release edge.
REQ-031 Done=1 in first GRANT cycle -> Grant high 1 cycle only; Data_Valid toggled with Next_priority changing 0->3 during GRANT -> Grant_idx unchanged.
REQ-032 rst=0 asserted in middle of a grant on idx 0 -> next cycle Grant=0, Grant_valid=0, Arb_ack=0, Timeout=0; after release, new grant starts with counter 0 (timeout at full TIMEOUT_CYC).
REQ-033 Continuous Data_Valid=1, Done pulsing every 2nd GRANT cycle, indices 0,1,2,3 -> Arb_ack count equals grant count, no cycle with >1 Grant bit set, one bubble between grants.
